// File: rtl/qu_common.sv
// Shared types and defaults for the Qu pipeline sequencing logic.
package qu_common;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_FLUSH  = 2'd3
  } qu_pipe_state_t;

  localparam int unsigned QU_PIPE_WARMUP_DEFAULT = 20;
  localparam int unsigned QU_PIPE_FLUSH_DEFAULT  = 2;

endpackage

// File: rtl/qu_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones, cleared by rst.
module qu_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/qu_pipe_ctrl.sv
// Qu front-end sequencing: per-stage stalls, scheduler enable, flush timing and
// post-reset warm-up, with saturating stall-cycle counters.
module qu_pipe_ctrl
  import qu_common::*;
#(
  parameter int unsigned WARMUP_CYCLES = QU_PIPE_WARMUP_DEFAULT,
  parameter int unsigned FLUSH_CYCLES  = QU_PIPE_FLUSH_DEFAULT,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ext_stall,
  input  logic                 if_id_afull,
  input  logic                 id_mp_afull,
  input  logic                 mp_rn_afull,
  input  logic                 rn_res_full,
  input  logic                 flush_req,
  output logic                 if_stall,
  output logic                 id_stall,
  output logic                 mp_stall,
  output logic                 rn_stall,
  output logic                 schedule_en,
  output logic                 flush_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] if_stall_cnt,
  output logic [CNT_WIDTH-1:0] id_stall_cnt,
  output logic [CNT_WIDTH-1:0] mp_stall_cnt,
  output logic [CNT_WIDTH-1:0] rn_stall_cnt
);

  localparam int unsigned TMAX = (WARMUP_CYCLES > FLUSH_CYCLES) ? WARMUP_CYCLES : FLUSH_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] WARM_LAST  = TW'(WARMUP_CYCLES - 1);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);

  qu_pipe_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           if_stall_q, id_stall_q, mp_stall_q, rn_stall_q;
  logic           if_stall_d, id_stall_d, mp_stall_d, rn_stall_d;
  logic           sched_q, sched_d;
  logic           flush_q, flush_d;
  logic           hold_all;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_RESET: begin
        state_d = S_WARMUP;
        timer_d = '0;
      end
      S_WARMUP: begin
        if (flush_req) begin
          state_d = S_FLUSH;
          timer_d = '0;
        end else if (timer_q == WARM_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RUN: begin
        if (flush_req) begin
          state_d = S_FLUSH;
          timer_d = '0;
        end
      end
      S_FLUSH: begin
        if (flush_req) begin
          timer_d = '0;
        end else if (timer_q == FLUSH_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RESET;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they stay aligned with state_o.
  always_comb begin
    hold_all   = (state_d == S_FLUSH);
    if_stall_d = hold_all | ext_stall | if_id_afull;
    id_stall_d = hold_all | ext_stall | id_mp_afull;
    mp_stall_d = hold_all | ext_stall | mp_rn_afull | rn_res_full;
    rn_stall_d = hold_all | ext_stall | rn_res_full;
    sched_d    = (state_d == S_RUN) & ~ext_stall;
    flush_d    = hold_all;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      timer_q    <= '0;
      if_stall_q <= 1'b1;
      id_stall_q <= 1'b1;
      mp_stall_q <= 1'b1;
      rn_stall_q <= 1'b1;
      sched_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      if_stall_q <= if_stall_d;
      id_stall_q <= id_stall_d;
      mp_stall_q <= mp_stall_d;
      rn_stall_q <= rn_stall_d;
      sched_q    <= sched_d;
      flush_q    <= flush_d;
    end
  end

  assign if_stall    = if_stall_q;
  assign id_stall    = id_stall_q;
  assign mp_stall    = mp_stall_q;
  assign rn_stall    = rn_stall_q;
  assign schedule_en = sched_q;
  assign flush_o     = flush_q;
  assign state_o     = state_q;

  qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_if_cnt (
    .clk(clk), .rst(rst), .inc(if_stall_q), .cnt(if_stall_cnt)
  );
  qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_id_cnt (
    .clk(clk), .rst(rst), .inc(id_stall_q), .cnt(id_stall_cnt)
  );
  qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_mp_cnt (
    .clk(clk), .rst(rst), .inc(mp_stall_q), .cnt(mp_stall_cnt)
  );
  qu_sat_counter #(.WIDTH(CNT_WIDTH)) u_rn_cnt (
    .clk(clk), .rst(rst), .inc(rn_stall_q), .cnt(rn_stall_cnt)
  );

endmodule

// File: tb/tb_qu_pipe_ctrl.sv
// Bench for qu_pipe_ctrl: default instance plus a small one (4-bit counters,
// short warm-up/flush), both checked every cycle against a phase-countdown model.
module tb_qu_pipe_ctrl;
  import qu_common::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ext_stall, if_id_afull, id_mp_afull, mp_rn_afull, rn_res_full, flush_req;

  logic        a_if, a_id, a_mp, a_rn, a_sched, a_flush;
  logic [1:0]  a_state;
  logic [31:0] a_cif, a_cid, a_cmp, a_crn;
  logic        b_if, b_id, b_mp, b_rn, b_sched, b_flush;
  logic [1:0]  b_state;
  logic [3:0]  b_cif, b_cid, b_cmp, b_crn;

  qu_pipe_ctrl dut_a (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .if_id_afull(if_id_afull),
    .id_mp_afull(id_mp_afull), .mp_rn_afull(mp_rn_afull), .rn_res_full(rn_res_full),
    .flush_req(flush_req), .if_stall(a_if), .id_stall(a_id), .mp_stall(a_mp),
    .rn_stall(a_rn), .schedule_en(a_sched), .flush_o(a_flush), .state_o(a_state),
    .if_stall_cnt(a_cif), .id_stall_cnt(a_cid), .mp_stall_cnt(a_cmp), .rn_stall_cnt(a_crn)
  );

  qu_pipe_ctrl #(.WARMUP_CYCLES(3), .FLUSH_CYCLES(1), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .if_id_afull(if_id_afull),
    .id_mp_afull(id_mp_afull), .mp_rn_afull(mp_rn_afull), .rn_res_full(rn_res_full),
    .flush_req(flush_req), .if_stall(b_if), .id_stall(b_id), .mp_stall(b_mp),
    .rn_stall(b_rn), .schedule_en(b_sched), .flush_o(b_flush), .state_o(b_state),
    .if_stall_cnt(b_cif), .id_stall_cnt(b_cid), .mp_stall_cnt(b_cmp), .rn_stall_cnt(b_crn)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase expressed as remaining warm-up / flush cycles.
  int unsigned     cw    [2] = '{32, 4};
  int              wl_p  [2] = '{20, 3};
  int              fl_p  [2] = '{2, 1};
  bit              m_rst [2] = '{1'b1, 1'b1};
  int              m_warm[2] = '{0, 0};
  int              m_fl  [2] = '{0, 0};
  bit [3:0]        m_stall[2];
  bit              m_sched[2];
  bit              m_flush[2];
  logic [1:0]      m_state[2];
  longint unsigned m_cnt [2][4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      longint unsigned cmax = (64'd1 << cw[k]) - 64'd1;
      if (rst) begin
        m_rst[k] = 1'b1;
        m_warm[k] = 0;
        m_fl[k] = 0;
        for (int s = 0; s < 4; s++) m_cnt[k][s] = 0;
      end else begin
        for (int s = 0; s < 4; s++)
          if (m_stall[k][s] && m_cnt[k][s] < cmax) m_cnt[k][s]++;
        if (m_rst[k]) begin
          m_rst[k] = 1'b0;
          m_warm[k] = wl_p[k];
        end else if (flush_req) begin
          m_fl[k] = fl_p[k];
          m_warm[k] = 0;
        end else if (m_fl[k] > 0) begin
          m_fl[k]--;
        end else if (m_warm[k] > 0) begin
          m_warm[k]--;
        end
      end
      if (m_rst[k]) begin
        m_state[k] = S_RESET;
        m_stall[k] = 4'hF;
        m_sched[k] = 1'b0;
        m_flush[k] = 1'b0;
      end else if (m_fl[k] > 0) begin
        m_state[k] = S_FLUSH;
        m_stall[k] = 4'hF;
        m_sched[k] = 1'b0;
        m_flush[k] = 1'b1;
      end else begin
        m_state[k] = (m_warm[k] > 0) ? S_WARMUP : S_RUN;
        m_stall[k] = {ext_stall | rn_res_full, ext_stall | mp_rn_afull | rn_res_full,
                      ext_stall | id_mp_afull, ext_stall | if_id_afull};
        m_sched[k] = (m_warm[k] == 0) && !ext_stall;
        m_flush[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("A.state", a_state, m_state[0]);   chk("B.state", b_state, m_state[1]);
    chk("A.flush", a_flush, m_flush[0]);   chk("B.flush", b_flush, m_flush[1]);
    chk("A.sched", a_sched, m_sched[0]);   chk("B.sched", b_sched, m_sched[1]);
    chk("A.if", a_if, m_stall[0][0]);      chk("B.if", b_if, m_stall[1][0]);
    chk("A.id", a_id, m_stall[0][1]);      chk("B.id", b_id, m_stall[1][1]);
    chk("A.mp", a_mp, m_stall[0][2]);      chk("B.mp", b_mp, m_stall[1][2]);
    chk("A.rn", a_rn, m_stall[0][3]);      chk("B.rn", b_rn, m_stall[1][3]);
    chk("A.if_cnt", a_cif, m_cnt[0][0]);   chk("B.if_cnt", b_cif, m_cnt[1][0]);
    chk("A.id_cnt", a_cid, m_cnt[0][1]);   chk("B.id_cnt", b_cid, m_cnt[1][1]);
    chk("A.mp_cnt", a_cmp, m_cnt[0][2]);   chk("B.mp_cnt", b_cmp, m_cnt[1][2]);
    chk("A.rn_cnt", a_crn, m_cnt[0][3]);   chk("B.rn_cnt", b_crn, m_cnt[1][3]);
  endtask

  initial begin
    rst = 1'b1; ext_stall = 1'b0; if_id_afull = 1'b0; id_mp_afull = 1'b0;
    mp_rn_afull = 1'b0; rn_res_full = 1'b0; flush_req = 1'b0;

    // Reset, release, warm-up into run
    repeat (5) step();
    rst = 1'b0;
    repeat (25) step();

    // mp_rn_afull pulse of 3 cycles
    mp_rn_afull = 1'b1;
    repeat (3) step();
    mp_rn_afull = 1'b0;
    repeat (3) step();

    // Single flush
    flush_req = 1'b1; step();
    flush_req = 1'b0; repeat (4) step();

    // Flush extended from its second cycle
    flush_req = 1'b1; step();
    flush_req = 1'b0; step();
    flush_req = 1'b1; step();
    flush_req = 1'b0; repeat (5) step();

    // Reset during flush, then reset during warm-up
    flush_req = 1'b1; step();
    flush_req = 1'b0; rst = 1'b1; step();
    rst = 1'b0; repeat (8) step();
    rst = 1'b1; step();
    rst = 1'b0; repeat (25) step();

    // ext_stall across a flush, then long enough to saturate 4-bit counters
    ext_stall = 1'b1; flush_req = 1'b1; step();
    flush_req = 1'b0; repeat (20) step();
    ext_stall = 1'b0; repeat (3) step();

    // Randomized traffic, with occasional flush and reset
    repeat (400) begin
      if_id_afull = ($urandom_range(0, 3) == 0);
      id_mp_afull = ($urandom_range(0, 3) == 0);
      mp_rn_afull = ($urandom_range(0, 3) == 0);
      rn_res_full = ($urandom_range(0, 5) == 0);
      ext_stall   = ($urandom_range(0, 9) == 0);
      flush_req   = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
